// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages: state encoding, bubble value
// and the field layout of the default 7 x 32-bit stage payload.
package pipe_pkg;

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam int PIPE_WIDTH = 224;
    localparam int FIELD_W    = 32;

    // All-zero instruction word decodes as a nop.
    localparam logic [PIPE_WIDTH-1:0] PIPE_BUBBLE = '0;

    localparam int OFF_INSTR = 0;
    localparam int OFF_PC    = 32;
    localparam int OFF_PC4   = 64;
    localparam int OFF_PC8   = 96;
    localparam int OFF_RT    = 128;
    localparam int OFF_ALU   = 160;
    localparam int OFF_IMM   = 192;

    function automatic logic [FIELD_W-1:0] get_field(
        input logic [PIPE_WIDTH-1:0] payload,
        input int                    off
    );
        return payload[off +: FIELD_W];
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One valid+data holding register; clear takes priority over load and may
// optionally restore the bubble value into the data register.
module pipe_entry #(
    parameter int               WIDTH  = 224,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clr,
    input  logic             i_clr_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= BUBBLE;
        end else if (i_clr) begin
            r_valid <= 1'b0;
            if (i_clr_data) begin
                r_data <= BUBBLE;
            end
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: main+skid buffer with valid/ready handshake,
// registered in_ready (no out_ready -> in_ready path) and synchronous flush.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int               WIDTH             = PIPE_WIDTH,
    parameter logic [WIDTH-1:0] BUBBLE            = {WIDTH{1'b0}},
    parameter bit               CLR_DATA_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // Handshake: a transfer happens on a rising clk edge where valid and ready
    // are both high; the producer holds valid and data stable until then.
    pipe_state_e      r_state;
    logic             r_in_ready;

    logic             w_push;
    logic             w_pop;
    logic             w_main_valid;
    logic             w_skid_valid;
    logic [WIDTH-1:0] w_main_data;
    logic [WIDTH-1:0] w_skid_data;
    logic [WIDTH-1:0] w_main_din;
    logic             w_main_load;
    logic             w_main_clr;
    logic             w_skid_load;
    logic             w_skid_clr;
    logic             w_clr_data;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = w_main_valid & out_ready;

    // The skid entry only ever feeds main when it holds data, preserving FIFO order.
    assign w_main_din = w_skid_valid ? w_skid_data : in_data;

    always_comb begin
        w_main_load = 1'b0;
        w_main_clr  = 1'b0;
        w_skid_load = 1'b0;
        w_skid_clr  = 1'b0;
        w_clr_data  = 1'b0;
        if (flush) begin
            w_main_clr = 1'b1;
            w_skid_clr = 1'b1;
            w_clr_data = CLR_DATA_ON_FLUSH;
        end else begin
            case (r_state)
                ST_EMPTY: w_main_load = w_push;
                ST_ONE: begin
                    w_main_load = w_push & w_pop;
                    w_skid_load = w_push & ~w_pop;
                    w_main_clr  = ~w_push & w_pop;
                end
                ST_FULL: begin
                    w_main_load = w_pop;
                    w_skid_clr  = w_pop;
                end
                default: begin
                    w_main_clr = 1'b1;
                    w_skid_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_push && !w_pop) begin
                        r_state    <= ST_FULL;
                        r_in_ready <= 1'b0;
                    end else if (!w_push && w_pop) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    pipe_entry #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_main (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_main_load),
        .i_data     (w_main_din),
        .i_clr      (w_main_clr),
        .i_clr_data (w_clr_data),
        .o_valid    (w_main_valid),
        .o_data     (w_main_data)
    );

    pipe_entry #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_skid_load),
        .i_data     (in_data),
        .i_clr      (w_skid_clr),
        .i_clr_data (w_clr_data),
        .o_valid    (w_skid_valid),
        .o_data     (w_skid_data)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = w_main_valid;
    assign out_data  = w_main_data;
    assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed vector table, async reset and
// combinational-path sequences, then randomized traffic against a queue model.
module tb_pipe_stage_elastic;

    localparam int W = 224;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int checks;
    int errors;

    pipe_stage_elastic dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver and checker tasks
    task automatic drive(input logic fl, input logic iv, input logic ordy, input logic [W-1:0] d);
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        in_data   = d;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] occ, input logic ir,
                                 input logic ov, input logic [W-1:0] od);
        check({tag, " occupancy"}, W'(occupancy), W'(occ));
        check({tag, " in_ready"},  W'(in_ready),  W'(ir));
        check({tag, " out_valid"}, W'(out_valid), W'(ov));
        check({tag, " out_data"},  out_data,      od);
    endtask

    // Directed vectors: inputs applied for one cycle, outputs expected after the edge
    typedef struct {
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [31:0] d;
        logic [1:0]  occ;
        logic        ir;
        logic        ov;
        logic [31:0] od;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    // Scoreboard / reference model
    logic [W-1:0] exp_q[$];
    logic [W-1:0] empty_data;
    int           seq_no;

    initial begin
        checks = 0;
        errors = 0;
        seq_no = 0;

        // streaming
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 32'h1,  2'd1, 1'b1, 1'b1, 32'h1};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h2,  2'd1, 1'b1, 1'b1, 32'h2};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h3,  2'd1, 1'b1, 1'b1, 32'h3};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h0,  2'd0, 1'b1, 1'b0, 32'h3};
        // backpressure: A, B fill; C held upstream then delivered
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'hA,  2'd1, 1'b1, 1'b1, 32'hA};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'hB,  2'd2, 1'b0, 1'b1, 32'hA};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'hC,  2'd2, 1'b0, 1'b1, 32'hA};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'hC,  2'd1, 1'b1, 1'b1, 32'hB};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'hC,  2'd1, 1'b1, 1'b1, 32'hC};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h0,  2'd0, 1'b1, 1'b0, 32'hC};
        // flush when full, with D pushing in the flush cycle
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h11, 2'd1, 1'b1, 1'b1, 32'h11};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h12, 2'd2, 1'b0, 1'b1, 32'h11};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 32'hD,  2'd0, 1'b1, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,  2'd0, 1'b1, 1'b0, 32'h0};
        // flush with pop of E
        vecs[14] = '{1'b0, 1'b1, 1'b0, 32'hE,  2'd1, 1'b1, 1'b1, 32'hE};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 32'h0,  2'd0, 1'b1, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 32'h20, 2'd1, 1'b1, 1'b1, 32'h20};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,  2'd1, 1'b1, 1'b1, 32'h20};
        vecs[18] = '{1'b1, 1'b1, 1'b0, 32'h21, 2'd0, 1'b1, 1'b0, 32'h0};

        drive(1'b0, 1'b0, 1'b0, '0);
        reset = 1'b1;
        #12;
        check_outputs("reset", 2'd0, 1'b1, 1'b0, '0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].ordy, W'(vecs[i].d));
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), vecs[i].occ, vecs[i].ir, vecs[i].ov, W'(vecs[i].od));
        end

        // Fill, then show in_ready ignores out_ready within the cycle
        drive(1'b0, 1'b1, 1'b0, W'(32'h30));
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("ir_comb_one", W'(in_ready), W'(1'b1));
        out_ready = 1'b0;
        in_data   = W'(32'h31);
        @(negedge clk);
        check_outputs("fill", 2'd2, 1'b0, 1'b1, W'(32'h30));
        out_ready = 1'b1;
        #1;
        check("ir_comb_full", W'(in_ready), W'(1'b0));
        drive(1'b0, 1'b0, 1'b0, '0);

        // Async reset mid-cycle, no clock edge in between
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_outputs("async_reset", 2'd0, 1'b1, 1'b0, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_outputs("post_reset", 2'd0, 1'b1, 1'b0, '0);

        // Randomized traffic against the queue model
        exp_q.delete();
        empty_data = '0;
        for (int c = 0; c < 10000; c++) begin
            logic         fl, iv, ordy, push, pop;
            logic [W-1:0] d;
            logic [W-1:0] popped;
            check_outputs("rand", 2'(exp_q.size()), exp_q.size() < 2, exp_q.size() > 0,
                          exp_q.size() > 0 ? exp_q[0] : empty_data);
            fl   = ($urandom_range(0, 99) < 4);
            iv   = ($urandom_range(0, 99) < 65);
            ordy = ($urandom_range(0, 99) < 55);
            seq_no++;
            d    = {$urandom(), 160'(0), 32'(seq_no)};
            drive(fl, iv, ordy, d);

            push = iv && (exp_q.size() < 2) && !fl;
            pop  = ordy && (exp_q.size() > 0);
            if (pop) begin
                popped = exp_q.pop_front();
                if (exp_q.size() == 0) empty_data = popped;
            end
            if (fl) begin
                exp_q.delete();
                empty_data = '0;
            end else if (push) begin
                exp_q.push_back(d);
            end
            @(negedge clk);
        end
        check_outputs("rand_end", 2'(exp_q.size()), exp_q.size() < 2, exp_q.size() > 0,
                      exp_q.size() > 0 ? exp_q[0] : empty_data);

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
